// File: rtl/dmem_sram_arbiter.sv
// Shares one single-port asynchronous SRAM between the IF fetch port and the MEM data port.
// Fixed MEM > IF priority; each access is IDLE -> ACCESS (WAIT_CYCLES) -> DONE (ack).
module dmem_sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_rw_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_wbe_n_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_ack_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o,
  output logic [3:0]        ram_be_n_o,
  output logic [31:0]       ram_wdata_o,
  output logic              ram_data_oe_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

  state_t            state, next_state;
  logic [3:0]        cnt, cnt_d;
  logic              own_mem, own_mem_d;
  logic              lat_rd, lat_rd_d;
  logic [3:0]        lat_wbe_n, lat_wbe_n_d;
  logic [31:0]       lat_wdata, lat_wdata_d;

  logic [ADDR_W-1:0] ram_addr_d;
  logic              ce_n_d, oe_n_d, we_n_d, data_oe_d;
  logic [3:0]        be_n_d;
  logic [31:0]       ram_wdata_d, if_rdata_d, mem_rdata_d;
  logic              if_ack_d, mem_ack_d, busy_d;

  // Only the word-address bits of the byte addresses reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (mem_req_i || if_req_i) next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0)           next_state = DONE;
      DONE:                               next_state = IDLE;
      default:                            next_state = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    cnt_d       = cnt;
    own_mem_d   = own_mem;
    lat_rd_d    = lat_rd;
    lat_wbe_n_d = lat_wbe_n;
    lat_wdata_d = lat_wdata;
    ram_addr_d  = ram_addr_o;
    ram_wdata_d = ram_wdata_o;
    if_rdata_d  = if_rdata_o;
    mem_rdata_d = mem_rdata_o;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = 4'b1111;
    data_oe_d   = 1'b0;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    busy_d      = (next_state != IDLE);

    unique case (state)
      IDLE: begin
        if (mem_req_i) begin
          own_mem_d   = 1'b1;
          lat_rd_d    = mem_rw_i;
          lat_wbe_n_d = mem_wbe_n_i;
          lat_wdata_d = mem_wdata_i;
          ram_addr_d  = mem_addr_i[ADDR_W+1:2];
          cnt_d       = WAIT_M1;
        end else if (if_req_i) begin
          own_mem_d   = 1'b0;
          lat_rd_d    = 1'b1;
          lat_wbe_n_d = 4'b0000;
          ram_addr_d  = if_addr_i[ADDR_W+1:2];
          cnt_d       = WAIT_M1;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          if (lat_rd) begin
            if (own_mem) mem_rdata_d = ram_rdata_i;
            else         if_rdata_d  = ram_rdata_i;
          end
          mem_ack_d = own_mem;
          if_ack_d  = !own_mem;
        end
      end
      default: ;
    endcase

    // Strobes for the coming cycle; the *_d latches already hold the grant values on entry.
    if (next_state == ACCESS) begin
      if (lat_rd_d) begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'b0000;
      end else begin
        ce_n_d      = (lat_wbe_n_d == 4'b1111);
        we_n_d      = (lat_wbe_n_d == 4'b1111);
        be_n_d      = lat_wbe_n_d;
        data_oe_d   = 1'b1;
        ram_wdata_d = lat_wdata_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 4'd0;
      own_mem       <= 1'b0;
      lat_rd        <= 1'b1;
      lat_wbe_n     <= 4'b1111;
      lat_wdata     <= '0;
      ram_addr_o    <= '0;
      ram_wdata_o   <= '0;
      if_rdata_o    <= '0;
      mem_rdata_o   <= '0;
      ram_ce_n_o    <= 1'b1;
      ram_oe_n_o    <= 1'b1;
      ram_we_n_o    <= 1'b1;
      ram_be_n_o    <= 4'b1111;
      ram_data_oe_o <= 1'b0;
      if_ack_o      <= 1'b0;
      mem_ack_o     <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      cnt           <= cnt_d;
      own_mem       <= own_mem_d;
      lat_rd        <= lat_rd_d;
      lat_wbe_n     <= lat_wbe_n_d;
      lat_wdata     <= lat_wdata_d;
      ram_addr_o    <= ram_addr_d;
      ram_wdata_o   <= ram_wdata_d;
      if_rdata_o    <= if_rdata_d;
      mem_rdata_o   <= mem_rdata_d;
      ram_ce_n_o    <= ce_n_d;
      ram_oe_n_o    <= oe_n_d;
      ram_we_n_o    <= we_n_d;
      ram_be_n_o    <= be_n_d;
      ram_data_oe_o <= data_oe_d;
      if_ack_o      <= if_ack_d;
      mem_ack_o     <= mem_ack_d;
      busy_o        <= busy_d;
    end
  end

endmodule

// File: doc/dmem_sram_arbiter.md
Name: dmem_sram_arbiter

Overview:
- Shares one single-port asynchronous SRAM between two requesters: the instruction-fetch port (read only) and the MEM-stage data port (read/write with byte enables).
- Sits between the IF/MEM pipeline stages and the SRAM pins.
- Sequences each access through a fixed wait-state FSM and returns a one-cycle ack with read data.
- When both requesters are pending, MEM always wins.

Parameters:
- ADDR_W, 20, SRAM word-address width. SRAM address = byte address [ADDR_W+1:2].
- WAIT_CYCLES, 1, number of cycles the SRAM strobes are held per access. Legal range is 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req_i  in  1  fetch read request
- if_addr_i  in  32  fetch byte address
- if_rdata_o  out  32  fetch read data, valid while if_ack_o is high
- if_ack_o  out  1  one-cycle completion pulse for the fetch port
- mem_req_i  in  1  data-port request
- mem_rw_i  in  1  1 = read, 0 = write
- mem_addr_i  in  32  data byte address
- mem_wbe_n_i  in  4  active-low byte write enables (1111 = no bytes)
- mem_wdata_i  in  32  store data
- mem_rdata_o  out  32  load data, valid while mem_ack_o is high
- mem_ack_o  out  1  one-cycle completion pulse for the data port
- ram_addr_o  out  ADDR_W  SRAM word address
- ram_ce_n_o  out  1  chip enable, active-low
- ram_oe_n_o  out  1  output enable, active-low
- ram_we_n_o  out  1  write enable, active-low
- ram_be_n_o  out  4  byte enables, active-low
- ram_wdata_o  out  32  write data to the pad
- ram_data_oe_o  out  1  1 = drive the data pad with ram_wdata_o
- ram_rdata_i  in  32  data from the pad
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - ram_ce_n_o, ram_oe_n_o, ram_we_n_o = 1; ram_be_n_o = 1111; ram_data_oe_o = 0.
  - ram_addr_o, ram_wdata_o, if_rdata_o, mem_rdata_o = 0.
  - Both acks = 0; busy_o = 0; wait counter = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_req_i is high, grant MEM; else if if_req_i is high, grant IF; else stay in IDLE.
  - On grant, latch the owner, word address, rw, wbe_n and wdata. An IF grant is always a read with be_n = 0000.
  - Load the counter with WAIT_CYCLES-1 and go to ACCESS.
- ACCESS:
  - Lasts exactly WAIT_CYCLES cycles, decrementing the counter each cycle.
  - ram_ce_n_o = 0 throughout.
  - Read access: ram_oe_n_o = 0, ram_be_n_o = 0000, ram_data_oe_o = 0.
  - Write access: ram_we_n_o = 0, ram_be_n_o = latched wbe_n, ram_data_oe_o = 1, ram_wdata_o = latched wdata.
  - Write with wbe_n = 1111: a no-op. ram_we_n_o stays 1 and ram_ce_n_o stays 1, but the FSM timing is unchanged and the access is still acked.
  - When the counter reaches 0: for a read, capture ram_rdata_i into the owner's rdata register; then go to DONE.
- DONE:
  - Strobes return to their reset values; ram_addr_o is held.
  - The owner's ack is high for exactly this one cycle, and its rdata is valid.
  - Always returns to IDLE next cycle. There is no back-to-back grant from DONE.
- Timing:
  - Request sampled in IDLE at cycle T.
  - ACCESS occupies cycles T+1 .. T+WAIT_CYCLES.
  - Ack occurs in cycle T+WAIT_CYCLES+1.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- Requester rules:
  - Hold req, address and data stable until ack. Inputs are sampled only at grant; changes after grant are ignored.
  - A req dropped after grant does not cancel the access: it completes and still acks.
  - A req still high in the cycle after ack is treated as a new request.
- Priority: fixed MEM > IF. IF waits while MEM requests, because a MEM stall also stalls IF.
- Read data: if_rdata_o and mem_rdata_o hold their last captured value between accesses; only the owner's register updates.
- Acks: never both high in the same cycle.
- Reset in ACCESS or DONE: in the next cycle the state is IDLE, all strobes are deasserted, and no ack is issued for the aborted access.

Test Plan:
- WAIT_CYCLES=1, IF read at 0x0000_0010 with ram_rdata_i=0xDEADBEEF -> ram_addr_o=0x00004, ram_ce_n/oe_n low for 1 cycle, if_ack_o high at T+2 with if_rdata_o=0xDEADBEEF.
- if_req and mem_req (read, addr 0x40) both rise at cycle T -> mem_ack at T+2; IF is then granted at T+3 and if_ack at T+5. No overlapping acks.
- MEM write, addr 0x8, wbe_n=1110, wdata=0x000000AB -> ram_we_n low and ram_be_n=1110 during ACCESS, ram_data_oe=1, ram_wdata=0x000000AB; mem_ack one cycle; ram_oe_n stays high.
- WAIT_CYCLES=3, MEM read -> ce_n low for exactly 3 cycles; data captured on the 3rd; mem_ack at T+4; busy_o high T+1..T+4.
- MEM write with wbe_n=1111 -> ram_ce_n/we_n never asserted; mem_ack still at T+WAIT_CYCLES+1.
- rst asserted mid-ACCESS with WAIT_CYCLES=3 -> next cycle all strobes are at reset values, state IDLE, no ack; a new IF request after rst falls completes normally.
